// File: rtl/multi_wav_player.sv
// Multi-channel sample player: NUM_CH streams share one synchronous ROM, are scaled by a live
// volume and mixed with saturation to a signed 16-bit sample. Define WAV_MIX_STEREO_EN for panning.
module multi_wav_player #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned VOL_W  = 4,
  parameter int unsigned DIV    = 2177
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        trig,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        loop,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*ADDR_W-1:0] length,
  input  logic [NUM_CH*VOL_W-1:0]  vol,
`ifdef WAV_MIX_STEREO_EN
  input  logic [NUM_CH*2-1:0]      pan,
`endif
  output logic [ADDR_W-1:0]        rom_a,
  input  logic [DATA_W-1:0]        rom_d,
  output logic [NUM_CH-1:0]        playing,
  output logic [NUM_CH-1:0]        done,
  output logic [15:0]              audio_out,
`ifdef WAV_MIX_STEREO_EN
  output logic [15:0]              audio_out_r,
`endif
  output logic                     sample_valid
);

  localparam int unsigned PscW  = $clog2(DIV + 1);
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TermW = DATA_W + VOL_W + 1;
  localparam int unsigned AccW  = DATA_W + VOL_W + $clog2(NUM_CH) + 1;
  localparam int unsigned Shift = 16 - DATA_W - VOL_W;
  localparam int unsigned SatW  = AccW + Shift;
  localparam logic signed [SatW-1:0] SatMax = SatW'(32767);
  localparam logic signed [SatW-1:0] SatMin = SatW'(-32768);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StMix} state_e;

  state_e                   state_q, state_d;
  logic [PscW-1:0]          psc_q;
  logic                     tick;
  logic [ChW-1:0]           ch_q, ch_d;
  logic [NUM_CH-1:0]        pend_trig_q, pend_trig_d, pend_stop_q, pend_stop_d;
  logic [NUM_CH-1:0]        trig_all, stop_all;
  logic [NUM_CH-1:0]        playing_q, playing_d, loop_q, loop_d;
  logic [ADDR_W-1:0]        ptr_q [NUM_CH];
  logic [ADDR_W-1:0]        ptr_d [NUM_CH];
  logic [ADDR_W-1:0]        base_q [NUM_CH];
  logic [ADDR_W-1:0]        base_d [NUM_CH];
  logic [ADDR_W-1:0]        len_q [NUM_CH];
  logic [ADDR_W-1:0]        len_d [NUM_CH];
  logic [ADDR_W-1:0]        rom_a_q, rom_a_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic [15:0]              audio_q, audio_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] smp;
  logic signed [TermW-1:0]  term;
`ifdef WAV_MIX_STEREO_EN
  logic signed [AccW-1:0]   acc_r_q, acc_r_d;
  logic [15:0]              audio_r_q, audio_r_d;
`endif

  function automatic logic [15:0] sat16(input logic signed [AccW-1:0] a);
    logic signed [SatW-1:0] w;
    w = SatW'(a) <<< Shift;
    if (w > SatMax) return 16'h7fff;
    if (w < SatMin) return 16'h8000;
    return w[15:0];
  endfunction

  assign tick     = (psc_q == PscW'(DIV));
  assign trig_all = pend_trig_q | trig;
  assign stop_all = pend_stop_q | stop;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pend_trig_d = pend_trig_q | trig;
    pend_stop_d = pend_stop_q | stop;
    playing_d   = playing_q;
    loop_d      = loop_q;
    ptr_d       = ptr_q;
    base_d      = base_q;
    len_d       = len_q;
    rom_a_d     = rom_a_q;
    acc_d       = acc_q;
    audio_d     = audio_q;
    valid_d     = 1'b0;
    done        = '0;
    smp         = rom_d ^ {1'b1, {(DATA_W-1){1'b0}}};
    term        = '0;
`ifdef WAV_MIX_STEREO_EN
    acc_r_d     = acc_r_q;
    audio_r_d   = audio_r_q;
`endif

    // Pending requests are applied only on the tick, while the sequencer is idle.
    if (tick) begin
      pend_trig_d = '0;
      pend_stop_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (trig_all[c]) begin
          ptr_d[c]     = '0;
          playing_d[c] = 1'b1;
          base_d[c]    = base_addr[c*ADDR_W +: ADDR_W];
          len_d[c]     = length[c*ADDR_W +: ADDR_W];
          loop_d[c]    = loop[c];
        end else if (stop_all[c]) begin
          playing_d[c] = 1'b0;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StAddr;
          ch_d    = '0;
        end
      end
      StAddr: begin
        if (ch_q == '0) begin
          acc_d = '0;
`ifdef WAV_MIX_STEREO_EN
          acc_r_d = '0;
`endif
        end
        if (playing_q[ch_q]) rom_a_d = base_q[ch_q] + ptr_q[ch_q];
        state_d = StData;
      end
      StData: begin
        if (playing_q[ch_q]) begin
          term = TermW'(smp) * TermW'($signed({1'b0, vol[ch_q*VOL_W +: VOL_W]}));
          // len - 1 wraps to all-ones for length 0, giving the full 2^ADDR_W span.
          if (ptr_q[ch_q] == len_q[ch_q] - ADDR_W'(1)) begin
            if (loop_q[ch_q]) begin
              ptr_d[ch_q] = '0;
            end else begin
              playing_d[ch_q] = 1'b0;
              done[ch_q]      = 1'b1;
            end
          end else begin
            ptr_d[ch_q] = ptr_q[ch_q] + ADDR_W'(1);
          end
        end
`ifdef WAV_MIX_STEREO_EN
        if (pan[2*ch_q]) acc_d = acc_q + AccW'(term);
        if (pan[2*ch_q+1]) acc_r_d = acc_r_q + AccW'(term);
`else
        acc_d = acc_q + AccW'(term);
`endif
        if (ch_q == ChW'(NUM_CH - 1)) begin
          state_d = StMix;
          valid_d = 1'b1;
          audio_d = sat16(acc_d);
`ifdef WAV_MIX_STEREO_EN
          audio_r_d = sat16(acc_r_d);
`endif
        end else begin
          ch_d    = ch_q + ChW'(1);
          state_d = StAddr;
        end
      end
      StMix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      psc_q       <= '0;
      ch_q        <= '0;
      pend_trig_q <= '0;
      pend_stop_q <= '0;
      playing_q   <= '0;
      loop_q      <= '0;
      ptr_q       <= '{default: '0};
      base_q      <= '{default: '0};
      len_q       <= '{default: '0};
      rom_a_q     <= '0;
      acc_q       <= '0;
      audio_q     <= '0;
      valid_q     <= 1'b0;
`ifdef WAV_MIX_STEREO_EN
      acc_r_q     <= '0;
      audio_r_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psc_q       <= tick ? '0 : psc_q + PscW'(1);
      ch_q        <= ch_d;
      pend_trig_q <= pend_trig_d;
      pend_stop_q <= pend_stop_d;
      playing_q   <= playing_d;
      loop_q      <= loop_d;
      ptr_q       <= ptr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rom_a_q     <= rom_a_d;
      acc_q       <= acc_d;
      audio_q     <= audio_d;
      valid_q     <= valid_d;
`ifdef WAV_MIX_STEREO_EN
      acc_r_q     <= acc_r_d;
      audio_r_q   <= audio_r_d;
`endif
    end
  end

  // The address is driven straight from the ADDR cycle so the ROM data lands in DATA.
  assign rom_a        = rom_a_d;
  assign playing      = playing_q;
  assign audio_out    = audio_q;
  assign sample_valid = valid_q;
`ifdef WAV_MIX_STEREO_EN
  assign audio_out_r  = audio_r_q;
`endif

endmodule
